execute_muldiv: RTL and testbench



---
 rtl/execute_muldiv.sv | 202 ++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
// Results come from unsigned magnitudes, with a sign fix-up applied on the final edge.
// Divide-by-zero and signed overflow finish on the start edge.
module execute_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] MulDivResult
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(W - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [W-1:0]   W_ONE     = W'(1);
    localparam logic [2*W-1:0] DW_ONE    = (2 * W)'(1);
    localparam logic [W-1:0]   MIN_NEG   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       op_q, op_d;
    // Shared working register: {hi, lo}.
    // Multiply: hi is the partial product and lo holds the shifting multiplier.
    // Divide: hi is the partial remainder and lo holds the dividend shifting into the quotient.
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
    logic             neg_q, neg_d;      // negate product / quotient
    logic             neg_rem_q, neg_rem_d; // remainder follows dividend sign
    logic [W-1:0]     result_q, result_d;

    // Operand decode for the op presented in EX
    logic         is_div;
    logic         a_signed, b_signed;
    logic         a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div_by_zero, div_ovf;
    logic [W-1:0] special_result;

    // Sign interpretation and magnitudes of the incoming operands
    always_comb begin
        is_div   = funct3[2];
        // MULHU (011), DIVU (101) and REMU (111) are fully unsigned
        a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        // MULHSU (010) additionally treats rs2 as unsigned
        b_signed = a_signed && (funct3 != 3'b010);
        a_neg    = a_signed && SrcA[W-1];
        b_neg    = b_signed && SrcB[W-1];
        a_mag    = a_neg ? (~SrcA + W_ONE) : SrcA;
        b_mag    = b_neg ? (~SrcB + W_ONE) : SrcB;

        div_by_zero = is_div && (SrcB == '0);
        // Only the signed forms (DIV 100, REM 110) can overflow
        div_ovf     = is_div && !funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);

        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_by_zero) begin
            special_result = funct3[1] ? SrcA : '1;
        end else begin
            special_result = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration of the datapath
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift, div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] step_next;

    // Compute one multiply or divide step from the working registers
    always_comb begin
        // Multiply: add the multiplicand when the multiplier LSB is set, then shift right
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Divide: shift the next dividend bit in, trial-subtract, restore on borrow
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[W]) begin
            div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end

        step_next = op_q[2] ? div_next : mul_next;
    end

    // Sign fix-up and result selection after the last iteration
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quo_fixed, rem_fixed;
    logic [W-1:0]   final_result;

    // Apply signs to the final magnitudes and pick the half or part requested
    always_comb begin
        prod_fixed = neg_q ? (~step_next + DW_ONE) : step_next;
        quo_fixed  = neg_q ? (~step_next[W-1:0] + W_ONE) : step_next[W-1:0];
        rem_fixed  = neg_rem_q ? (~step_next[2*W-1:W] + W_ONE) : step_next[2*W-1:W];
        case (op_q)
            3'b000:                 final_result = prod_fixed[W-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_fixed[2*W-1:W];
            3'b100, 3'b101:         final_result = quo_fixed;
            default:                final_result = rem_fixed;
        endcase
    end

    // Next-state logic: flush overrides everything except reset
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d      = funct3;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        count_d   = '0;
                        if (div_by_zero || div_ovf) begin
                            result_d = special_result;
                            state_d  = DONE;
                        end else begin
                            // Divide shifts the dividend; multiply shifts the multiplier
                            acc_d   = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                            opb_d   = is_div ? b_mag : a_mag;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d   = step_next;
                    count_d = count_q + CNT_ONE;
                    if (count_q == LAST_ITER) begin
                        result_d = final_result;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    // Start is not accepted here; the pipeline is consuming the result
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign stall        = ((state_q == IDLE) && start) || (state_q == CALC);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign MulDivResult = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed testbench for execute_muldiv: result values, latency, stall/done behaviour,
// special cases, flush and reset.
module tb_execute_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] MulDivResult;

    int tests_run;
    int tests_failed;

    execute_muldiv #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .funct3       (funct3),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .MulDivResult (MulDivResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op at a falling edge.
    // Track cycles to the done pulse and the number of stalled cycles.
    // When hold is set, start is kept high through the DONE cycle, where it must be ignored.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit hold);
        int lat;
        int stall_cnt;
        bit seen;
        @(negedge clk);
        funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        #1;
        stall_cnt = stall ? 1 : 0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            #1;
            lat++;
            if (done) seen = 1'b1;
            else if (stall) stall_cnt++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, MulDivResult, exp);
        check_eq({tag, "_stallcyc"}, stall_cnt, exp_lat);
        check_eq({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
        $display("[TB] %s f=%0d a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) lat=%0d",
                 tag, f, a, b, MulDivResult, exp, lat);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_stall",  {31'd0, stall}, 32'd0);
        check_eq("reset_busy",   {31'd0, busy},  32'd0);
        check_eq("reset_done",   {31'd0, done},  32'd0);
        check_eq("reset_result", MulDivResult,   32'd0);

        // Multiplies
        run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        run_op("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
        run_op("mulhsu_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
        run_op("mulh_m1_5",    3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 33, 1'b0);
        run_op("mulhu_2p33",   3'b011, 32'h80000000, 32'd4,        32'd2,        33, 1'b0);

        // Divides
        run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
        run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
        run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 1'b0);
        run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
        run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);

        // Special cases finish on the start edge
        run_op("divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b0);
        run_op("remu_by0",     3'b111, 32'd5,        32'd0,        32'd5,        1, 1'b0);
        run_op("div_by0",      3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1, 1'b0);
        run_op("rem_by0",      3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, 1'b0);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1'b0);

        // Back-to-back multiplies, start held through DONE
        run_op("b2b_3x4",      3'b000, 32'd3,        32'd4,        32'd12,       33, 1'b1);
        run_op("b2b_5x6",      3'b000, 32'd5,        32'd6,        32'd30,       33, 1'b0);

        // Flush 10 cycles into a DIV: result must keep the previous value (30)
        @(negedge clk);
        funct3 = 3'b100;
        SrcA   = 32'd1000;
        SrcB   = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check_eq("flush_stall_before", {31'd0, stall}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_busy",   {31'd0, busy},  32'd0);
        check_eq("flush_stall",  {31'd0, stall}, 32'd0);
        check_eq("flush_result", MulDivResult,   32'd30);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("flush_no_done", done_cnt, 0);
        $display("[TB] flush mid-DIV result=0x%08h done_pulses=%0d", MulDivResult, done_cnt);

        // Reset in the middle of a MUL
        @(negedge clk);
        funct3 = 3'b000;
        SrcA   = 32'd3;
        SrcB   = 32'd4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_stall",  {31'd0, stall}, 32'd0);
        check_eq("rst_busy",   {31'd0, busy},  32'd0);
        check_eq("rst_done",   {31'd0, done},  32'd0);
        check_eq("rst_result", MulDivResult,   32'd0);
        $display("[TB] reset mid-MUL busy=%0d result=0x%08h", busy, MulDivResult);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
